// File: rtl/multdiv_sequencer.sv
// Control sequencer for the multi-cycle multiply/divide unit: owns the
// operation latch and the iteration counter, and drives the shared datapath.
module multdiv_sequencer #(
  parameter int CYCLES = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ctrl_MULT,
  input  logic       ctrl_DIV,
  input  logic       stall,
  output logic       op_is_div,
  output logic       load,
  output logic       step,
  output logic [4:0] iter,
  output logic       busy,
  output logic       data_ready,
  output logic       fault
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [4:0] LAST = 5'(CYCLES - 1);

  state_t state;
  logic   start_ok;
  logic   start_clash;

  assign start_ok    = ctrl_MULT ^ ctrl_DIV;
  assign start_clash = ctrl_MULT & ctrl_DIV;

  // A clashing request only raises fault; it never disturbs the sequence.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      iter      <= 5'd0;
      op_is_div <= 1'b0;
      fault     <= 1'b0;
    end else begin
      fault <= start_clash;
      if (start_ok) begin
        state     <= LOAD;
        op_is_div <= ctrl_DIV;
        iter      <= 5'd0;
      end else begin
        case (state)
          IDLE: state <= IDLE;
          LOAD: begin
            state <= RUN;
            iter  <= 5'd0;
          end
          RUN: begin
            if (!stall) begin
              if (iter == LAST) state <= DONE;
              else              iter  <= iter + 5'd1;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Moore decode; step alone also sees the live stall input.
  assign busy       = (state == LOAD) || (state == RUN);
  assign load       = (state == LOAD);
  assign step       = (state == RUN) && !stall;
  assign data_ready = (state == DONE);

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer: one 32-iteration and one 4-iteration
// instance, each scenario in its own task with hand-derived cycle counts.
module tb_multdiv_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic m32 = 0, d32 = 0, s32 = 0;
  logic m4 = 0, d4 = 0, s4 = 0;
  logic op32, load32, step32, busy32, dr32, fault32;
  logic op4, load4, step4, busy4, dr4, fault4;
  logic [4:0] iter32, iter4;
  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  multdiv_sequencer #(.CYCLES(32)) dut32 (
    .clock(clock), .reset(reset), .ctrl_MULT(m32), .ctrl_DIV(d32), .stall(s32),
    .op_is_div(op32), .load(load32), .step(step32), .iter(iter32),
    .busy(busy32), .data_ready(dr32), .fault(fault32));

  multdiv_sequencer #(.CYCLES(4)) dut4 (
    .clock(clock), .reset(reset), .ctrl_MULT(m4), .ctrl_DIV(d4), .stall(s4),
    .op_is_div(op4), .load(load4), .step(step4), .iter(iter4),
    .busy(busy4), .data_ready(dr4), .fault(fault4));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [10:0] all32, all4;
    reset = 1'b1; m32 = 1'b1;
    tick();
    m32 = 1'b0;
    tick();
    all32 = {op32, load32, step32, iter32, busy32, dr32, fault32};
    all4  = {op4, load4, step4, iter4, busy4, dr4, fault4};
    vectors++;
    if (all32 !== 11'd0) begin
      miscompares++; $display("FAIL reset32 outputs got %b want 0", all32);
    end
    vectors++;
    if (all4 !== 11'd0) begin
      miscompares++; $display("FAIL reset4 outputs got %b want 0", all4);
    end
    reset = 1'b0;
    tick();
    vectors++;
    if (busy32 !== 1'b0 || load32 !== 1'b0) begin
      miscompares++; $display("FAIL reset_priority busy=%b load=%b want 0 0", busy32, load32);
    end
  endtask

  task automatic test_mult();
    int steps = 0, loads = 0, dr_at = -1, dr_cnt = 0;
    bit iter_ok = 1;
    logic dr_op = 1'bx;
    m32 = 1'b1;
    tick();
    m32 = 1'b0;
    vectors++;
    if (load32 !== 1'b1 || busy32 !== 1'b1 || step32 !== 1'b0) begin
      miscompares++; $display("FAIL mult_load load=%b busy=%b step=%b want 1 1 0", load32, busy32, step32);
    end
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (load32) loads++;
      if (step32) begin
        steps++;
        if (iter32 !== 5'(c - 1)) iter_ok = 0;
      end
      if (dr32) begin
        dr_cnt++;
        if (dr_at < 0) begin dr_at = c; dr_op = op32; end
      end
    end
    vectors++;
    if (steps !== 32) begin miscompares++; $display("FAIL mult_steps got %0d want 32", steps); end
    vectors++;
    if (!iter_ok) begin miscompares++; $display("FAIL mult_iter_seq got bad want 0..31"); end
    vectors++;
    if (dr_at !== 33 || dr_cnt !== 1) begin
      miscompares++; $display("FAIL mult_ready at=%0d count=%0d want 33 1", dr_at, dr_cnt);
    end
    vectors++;
    if (dr_op !== 1'b0) begin miscompares++; $display("FAIL mult_op got %b want 0", dr_op); end
    vectors++;
    if (loads !== 0 || busy32 !== 1'b0) begin
      miscompares++; $display("FAIL mult_after loads=%0d busy=%b want 0 0", loads, busy32);
    end
  endtask

  task automatic test_div_stall();
    int c = 0, dr_at = -1;
    logic dr_op = 1'bx;
    d32 = 1'b1;
    tick();
    d32 = 1'b0;
    repeat (11) begin tick(); c++; end
    vectors++;
    if (iter32 !== 5'd10 || step32 !== 1'b1) begin
      miscompares++; $display("FAIL div_pre_stall iter=%0d step=%b want 10 1", iter32, step32);
    end
    s32 = 1'b1;
    #1;
    vectors++;
    if (step32 !== 1'b0) begin miscompares++; $display("FAIL div_stall_step got %b want 0", step32); end
    for (int k = 0; k < 3; k++) begin
      tick(); c++;
      vectors++;
      if (iter32 !== 5'd10 || busy32 !== 1'b1) begin
        miscompares++; $display("FAIL div_stall_hold k=%0d iter=%0d busy=%b want 10 1", k, iter32, busy32);
      end
    end
    s32 = 1'b0;
    while (c < 45) begin
      tick(); c++;
      if (dr32 && dr_at < 0) begin dr_at = c; dr_op = op32; end
    end
    vectors++;
    if (dr_at !== 36 || dr_op !== 1'b1) begin
      miscompares++; $display("FAIL div_ready at=%0d op=%b want 36 1", dr_at, dr_op);
    end
  endtask

  task automatic test_fault();
    int dr_at = -1;
    m32 = 1'b1; d32 = 1'b1;
    tick();
    m32 = 1'b0; d32 = 1'b0;
    vectors++;
    if (fault32 !== 1'b1 || busy32 !== 1'b0 || load32 !== 1'b0) begin
      miscompares++; $display("FAIL fault_idle fault=%b busy=%b load=%b want 1 0 0", fault32, busy32, load32);
    end
    tick();
    vectors++;
    if (fault32 !== 1'b0 || busy32 !== 1'b0) begin
      miscompares++; $display("FAIL fault_idle_clear fault=%b busy=%b want 0 0", fault32, busy32);
    end
    m32 = 1'b1;
    tick();
    m32 = 1'b0;
    repeat (6) tick();
    m32 = 1'b1; d32 = 1'b1;
    tick();
    m32 = 1'b0; d32 = 1'b0;
    vectors++;
    if (fault32 !== 1'b1 || iter32 !== 5'd6 || op32 !== 1'b0 || load32 !== 1'b0) begin
      miscompares++; $display("FAIL fault_run fault=%b iter=%0d op=%b load=%b want 1 6 0 0", fault32, iter32, op32, load32);
    end
    for (int c = 8; c <= 40; c++) begin
      tick();
      if (dr32 && dr_at < 0) dr_at = c;
    end
    vectors++;
    if (dr_at !== 33) begin miscompares++; $display("FAIL fault_run_ready at=%0d want 33", dr_at); end
  endtask

  task automatic test_restart();
    int dr_at = -1, dr_cnt = 0;
    m32 = 1'b1;
    tick();
    m32 = 1'b0;
    repeat (21) tick();
    vectors++;
    if (iter32 !== 5'd20) begin miscompares++; $display("FAIL restart_pre iter=%0d want 20", iter32); end
    d32 = 1'b1;
    tick();
    d32 = 1'b0;
    vectors++;
    if (load32 !== 1'b1 || iter32 !== 5'd0 || op32 !== 1'b1) begin
      miscompares++; $display("FAIL restart_load load=%b iter=%0d op=%b want 1 0 1", load32, iter32, op32);
    end
    for (int c = 1; c <= 45; c++) begin
      tick();
      if (dr32) begin dr_cnt++; if (dr_at < 0) dr_at = c; end
    end
    vectors++;
    if (dr_cnt !== 1 || dr_at !== 33) begin
      miscompares++; $display("FAIL restart_ready count=%0d at=%0d want 1 33", dr_cnt, dr_at);
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] all32;
    int dr_cnt = 0, dr_at = -1;
    d32 = 1'b1;
    tick();
    d32 = 1'b0;
    repeat (16) tick();
    vectors++;
    if (iter32 !== 5'd15 || op32 !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_pre iter=%0d op=%b want 15 1", iter32, op32);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    all32 = {op32, load32, step32, iter32, busy32, dr32, fault32};
    vectors++;
    if (all32 !== 11'd0) begin miscompares++; $display("FAIL rstmid_outputs got %b want 0", all32); end
    repeat (40) begin tick(); if (dr32 || busy32 || fault32) dr_cnt++; end
    vectors++;
    if (dr_cnt !== 0) begin miscompares++; $display("FAIL rstmid_quiet active=%0d want 0", dr_cnt); end
    m32 = 1'b1;
    tick();
    m32 = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (dr32 && dr_at < 0) dr_at = c;
    end
    vectors++;
    if (dr_at !== 33) begin miscompares++; $display("FAIL rstmid_mult at=%0d want 33", dr_at); end
  endtask

  task automatic test_back_to_back();
    int hi_iter = 0;
    m4 = 1'b1;
    tick();
    m4 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (int'(iter4) > hi_iter) hi_iter = int'(iter4);
    end
    vectors++;
    if (iter4 !== 5'd3 || step4 !== 1'b1) begin
      miscompares++; $display("FAIL b2b_last iter=%0d step=%b want 3 1", iter4, step4);
    end
    tick();
    vectors++;
    if (dr4 !== 1'b1 || op4 !== 1'b0 || busy4 !== 1'b0 || iter4 !== 5'd3) begin
      miscompares++; $display("FAIL b2b_first dr=%b op=%b busy=%b iter=%0d want 1 0 0 3", dr4, op4, busy4, iter4);
    end
    d4 = 1'b1;
    tick();
    d4 = 1'b0;
    vectors++;
    if (load4 !== 1'b1 || op4 !== 1'b1 || dr4 !== 1'b0) begin
      miscompares++; $display("FAIL b2b_load load=%b op=%b dr=%b want 1 1 0", load4, op4, dr4);
    end
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (int'(iter4) > hi_iter) hi_iter = int'(iter4);
      vectors++;
      if (dr4 !== 1'b0) begin miscompares++; $display("FAIL b2b_early c=%0d dr=%b want 0", c, dr4); end
    end
    tick();
    vectors++;
    if (dr4 !== 1'b1 || op4 !== 1'b1) begin
      miscompares++; $display("FAIL b2b_second dr=%b op=%b want 1 1", dr4, op4);
    end
    vectors++;
    if (hi_iter !== 3) begin miscompares++; $display("FAIL b2b_iter_max got %0d want 3", hi_iter); end
    tick();
    vectors++;
    if (dr4 !== 1'b0 || busy4 !== 1'b0) begin
      miscompares++; $display("FAIL b2b_idle dr=%b busy=%b want 0 0", dr4, busy4);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div_stall();
    tick();
    test_fault();
    tick();
    test_restart();
    tick();
    test_reset_mid();
    tick();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
